// File: rtl/zt_des_cuckoo_cmd_sched.sv
// ----------------------------------------------------------------------------
// zt_des_cuckoo_cmd_sched
// Upstream command scheduler for the 1-search/1-update cuckoo table.
// Buffers a unified search/insert/delete command stream in a small in-order
// queue. It dispatches the queue head to the table search_0 or update_1 port.
// It inserts a forced idle cycle after MAXBURST back-to-back searches so the
// table update FIFO can drain. It returns tagged responses in command order.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   i_cmd_vld / o_cmd_rdy    command handshake (o_cmd_rdy = queue not full)
//   i_cmd_op                 0=search 1=insert 2=delete 3=reserved (error)
//   i_cmd_key/dat/tag        command key, insert data, caller tag
//   o_rsp_vld/tag/hit/dat/err  in-order response, 1-cycle pulse
//   i_tbl_ready              table ready; no dispatch while low
//   o_search_0, o_sr_key_0   table search strobe and key
//   i_sr_hit_0, i_sr_dout_0  table search result, SRCH_LAT cycles after strobe
//   o_update_1, o_up_key_1, o_up_din_1, o_up_del_1   table update port
//   i_up_bp_1                table update backpressure
// ----------------------------------------------------------------------------
module zt_des_cuckoo_cmd_sched #(
    parameter int unsigned KYWIDTH  = 5,
    parameter int unsigned DTWIDTH  = 1,
    parameter int unsigned TAGWIDTH = 4,
    parameter int unsigned CMDDEPTH = 4,
    parameter int unsigned SRCH_LAT = 2,
    parameter int unsigned MAXBURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_cmd_vld,
    output logic                o_cmd_rdy,
    input  logic [1:0]          i_cmd_op,
    input  logic [KYWIDTH-1:0]  i_cmd_key,
    input  logic [DTWIDTH-1:0]  i_cmd_dat,
    input  logic [TAGWIDTH-1:0] i_cmd_tag,
    output logic                o_rsp_vld,
    output logic [TAGWIDTH-1:0] o_rsp_tag,
    output logic                o_rsp_hit,
    output logic [DTWIDTH-1:0]  o_rsp_dat,
    output logic                o_rsp_err,
    input  logic                i_tbl_ready,
    output logic                o_search_0,
    output logic [KYWIDTH-1:0]  o_sr_key_0,
    input  logic                i_sr_hit_0,
    input  logic [DTWIDTH-1:0]  i_sr_dout_0,
    output logic                o_update_1,
    output logic [KYWIDTH-1:0]  o_up_key_1,
    output logic [DTWIDTH-1:0]  o_up_din_1,
    output logic                o_up_del_1,
    input  logic                i_up_bp_1
);

    localparam int unsigned PTRW  = (CMDDEPTH > 1) ? $clog2(CMDDEPTH) : 1;
    localparam int unsigned CNTW  = $clog2(CMDDEPTH + 1);
    localparam int unsigned BRSTW = $clog2(MAXBURST + 1);

    localparam logic [1:0] OP_SRCH = 2'd0;
    localparam logic [1:0] OP_INS  = 2'd1;
    localparam logic [1:0] OP_DEL  = 2'd2;

    typedef struct packed {
        logic [1:0]          op;
        logic [KYWIDTH-1:0]  key;
        logic [DTWIDTH-1:0]  dat;
        logic [TAGWIDTH-1:0] tag;
    } cmd_t;

    typedef struct packed {
        logic                vld;
        logic [TAGWIDTH-1:0] tag;
        logic                srch;
        logic                err;
    } rsp_ent_t;

    // Command queue storage and pointers
    cmd_t               r_q [CMDDEPTH];
    logic [PTRW-1:0]    r_head;
    logic [PTRW-1:0]    r_tail;
    logic [CNTW-1:0]    r_count;
    logic               r_cmd_rdy;

    // Dispatch state and registered table port
    logic [BRSTW-1:0]   r_burst;
    logic               r_search_0;
    logic [KYWIDTH-1:0] r_sr_key_0;
    logic               r_update_1;
    logic [KYWIDTH-1:0] r_up_key_1;
    logic [DTWIDTH-1:0] r_up_din_1;
    logic               r_up_del_1;

    // r_port mirrors the command on the table port this cycle; the pipe
    // then delays it SRCH_LAT cycles to line up with the search result.
    rsp_ent_t           r_port;
    rsp_ent_t           r_pipe [SRCH_LAT];

    cmd_t               w_head;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_iss_srch;
    logic               w_iss_upd;
    logic               w_iss_err;
    logic [CNTW-1:0]    w_count_nxt;
    rsp_ent_t           w_out;

    assign w_head  = r_q[r_head];
    assign w_empty = (r_count == '0);
    assign w_push  = i_cmd_vld & r_cmd_rdy;

    // Head dispatch decision: strictly in order, one command per cycle
    always_comb begin
        w_pop      = 1'b0;
        w_iss_srch = 1'b0;
        w_iss_upd  = 1'b0;
        w_iss_err  = 1'b0;
        if (!w_empty && i_tbl_ready) begin
            case (w_head.op)
                OP_SRCH: begin
                    if (r_burst < BRSTW'(MAXBURST)) begin
                        w_pop      = 1'b1;
                        w_iss_srch = 1'b1;
                    end
                end
                OP_INS, OP_DEL: begin
                    if (!i_up_bp_1) begin
                        w_pop     = 1'b1;
                        w_iss_upd = 1'b1;
                    end
                end
                default: begin
                    w_pop     = 1'b1;
                    w_iss_err = 1'b1;
                end
            endcase
        end
    end

    // Occupancy next value; simultaneous push and pop leaves it unchanged
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNTW'(1);
            2'b01:   w_count_nxt = r_count - CNTW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Queue payload write (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_tail] <= '{op: i_cmd_op, key: i_cmd_key, dat: i_cmd_dat, tag: i_cmd_tag};
        end
    end

    // Control, table port and response pipe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_cmd_rdy  <= 1'b0;
            r_burst    <= '0;
            r_search_0 <= 1'b0;
            r_sr_key_0 <= '0;
            r_update_1 <= 1'b0;
            r_up_key_1 <= '0;
            r_up_din_1 <= '0;
            r_up_del_1 <= 1'b0;
            r_port     <= '0;
            for (int i = 0; i < int'(SRCH_LAT); i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTRW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTRW'(1);
            end
            r_count   <= w_count_nxt;
            r_cmd_rdy <= (w_count_nxt != CNTW'(CMDDEPTH));

            // Any cycle without a search issue restarts the burst window
            r_burst <= w_iss_srch ? (r_burst + BRSTW'(1)) : '0;

            r_search_0 <= w_iss_srch;
            r_sr_key_0 <= w_iss_srch ? w_head.key : '0;
            r_update_1 <= w_iss_upd;
            r_up_key_1 <= w_iss_upd ? w_head.key : '0;
            r_up_din_1 <= w_iss_upd ? w_head.dat : '0;
            r_up_del_1 <= w_iss_upd & (w_head.op == OP_DEL);

            r_port.vld  <= w_pop;
            r_port.tag  <= w_pop ? w_head.tag : '0;
            r_port.srch <= w_iss_srch;
            r_port.err  <= w_iss_err;

            r_pipe[0] <= r_port;
            for (int i = 1; i < int'(SRCH_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_out = r_pipe[SRCH_LAT-1];

    assign o_cmd_rdy  = r_cmd_rdy;
    assign o_search_0 = r_search_0;
    assign o_sr_key_0 = r_sr_key_0;
    assign o_update_1 = r_update_1;
    assign o_up_key_1 = r_up_key_1;
    assign o_up_din_1 = r_up_din_1;
    assign o_up_del_1 = r_up_del_1;

    // Search result arrives on the same cycle the pipe entry emerges
    assign o_rsp_vld = w_out.vld;
    assign o_rsp_tag = w_out.tag;
    assign o_rsp_err = w_out.err;
    assign o_rsp_hit = w_out.vld & w_out.srch & i_sr_hit_0;
    assign o_rsp_dat = o_rsp_hit ? i_sr_dout_0 : '0;

endmodule

// File: tb/tb_zt_des_cuckoo_cmd_sched.sv
// ----------------------------------------------------------------------------
// tb_zt_des_cuckoo_cmd_sched
// Bench for the cuckoo command scheduler. A behavioural table answers
// searches SRCH_LAT cycles after search_0. A reference map predicts each
// response when the command is accepted, and the per-cycle tick compares
// responses in order.
// ----------------------------------------------------------------------------
module tb_zt_des_cuckoo_cmd_sched;

    localparam int unsigned SRCH_LAT = 2;
    localparam int unsigned MAXBURST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_cmd_vld = 1'b0;
    logic       o_cmd_rdy;
    logic [1:0] i_cmd_op = 2'd0;
    logic [4:0] i_cmd_key = 5'd0;
    logic       i_cmd_dat = 1'b0;
    logic [3:0] i_cmd_tag = 4'd0;
    logic       o_rsp_vld;
    logic [3:0] o_rsp_tag;
    logic       o_rsp_hit;
    logic       o_rsp_dat;
    logic       o_rsp_err;
    logic       i_tbl_ready = 1'b1;
    logic       o_search_0;
    logic [4:0] o_sr_key_0;
    logic       i_sr_hit_0 = 1'b0;
    logic       i_sr_dout_0 = 1'b0;
    logic       o_update_1;
    logic [4:0] o_up_key_1;
    logic       o_up_din_1;
    logic       o_up_del_1;
    logic       i_up_bp_1 = 1'b0;

    always #5 clk = ~clk;

    zt_des_cuckoo_cmd_sched #(
        .KYWIDTH(5), .DTWIDTH(1), .TAGWIDTH(4), .CMDDEPTH(4),
        .SRCH_LAT(SRCH_LAT), .MAXBURST(MAXBURST)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_vld(i_cmd_vld), .o_cmd_rdy(o_cmd_rdy), .i_cmd_op(i_cmd_op),
        .i_cmd_key(i_cmd_key), .i_cmd_dat(i_cmd_dat), .i_cmd_tag(i_cmd_tag),
        .o_rsp_vld(o_rsp_vld), .o_rsp_tag(o_rsp_tag), .o_rsp_hit(o_rsp_hit),
        .o_rsp_dat(o_rsp_dat), .o_rsp_err(o_rsp_err),
        .i_tbl_ready(i_tbl_ready), .o_search_0(o_search_0), .o_sr_key_0(o_sr_key_0),
        .i_sr_hit_0(i_sr_hit_0), .i_sr_dout_0(i_sr_dout_0),
        .o_update_1(o_update_1), .o_up_key_1(o_up_key_1), .o_up_din_1(o_up_din_1),
        .o_up_del_1(o_up_del_1), .i_up_bp_1(i_up_bp_1)
    );

    typedef struct packed {
        logic [3:0] tag;
        logic       hit;
        logic       dat;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference map (updated at accept) and table model (updated at update_1)
    logic ref_v [32];
    logic ref_d [32];
    logic tbl_v [32];
    logic tbl_d [32];

    // Search result delay line: index 0 = issued this cycle
    logic hist_v [SRCH_LAT+1];
    logic hist_h [SRCH_LAT+1];
    logic hist_d [SRCH_LAT+1];

    int   s0_run = 0;
    bit   s0_log_en = 1'b0;
    bit   s0_log[$];

    // One clock step: table model and response checks mid-cycle, then return
    // just after the next rising edge.
    task automatic tick();
        exp_t e;
        exp_t got;
        @(negedge clk);
        if (rst) begin
            for (int k = 0; k <= int'(SRCH_LAT); k++) begin
                hist_v[k] = 1'b0; hist_h[k] = 1'b0; hist_d[k] = 1'b0;
            end
            s0_run = 0;
        end else begin
            if (o_update_1) begin
                tbl_v[o_up_key_1] = !o_up_del_1;
                tbl_d[o_up_key_1] = o_up_din_1;
            end
            for (int k = int'(SRCH_LAT); k > 0; k--) begin
                hist_v[k] = hist_v[k-1]; hist_h[k] = hist_h[k-1]; hist_d[k] = hist_d[k-1];
            end
            hist_v[0] = o_search_0;
            hist_h[0] = o_search_0 ? tbl_v[o_sr_key_0] : 1'b0;
            hist_d[0] = o_search_0 ? tbl_d[o_sr_key_0] : 1'b0;
        end
        // Junk on the result bus whenever no search result is due
        if (hist_v[SRCH_LAT]) begin
            i_sr_hit_0  = hist_h[SRCH_LAT];
            i_sr_dout_0 = hist_h[SRCH_LAT] ? hist_d[SRCH_LAT] : 1'($urandom);
        end else begin
            i_sr_hit_0  = 1'($urandom);
            i_sr_dout_0 = 1'($urandom);
        end
        #1;
        if (!rst) begin
            if (o_rsp_vld !== 1'b0) begin
                n_cmp++;
                got = {o_rsp_tag, o_rsp_hit, o_rsp_dat, o_rsp_err};
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL rsp_unexpected: rsp_vld=%b tag=%0d, required no response", o_rsp_vld, o_rsp_tag);
                end else begin
                    e = sb.pop_front();
                    if (got !== e)
                        begin
                            n_bad++;
                            $display("FAIL rsp_fields: got tag=%0d hit=%b dat=%b err=%b, required tag=%0d hit=%b dat=%b err=%b",
                                     got.tag, got.hit, got.dat, got.err, e.tag, e.hit, e.dat, e.err);
                        end
                end
            end
            if (o_search_0) begin
                s0_run++;
                n_cmp++;
                if (s0_run > int'(MAXBURST)) begin
                    n_bad++;
                    $display("FAIL burst_limit: search_0 high %0d consecutive cycles, required <= %0d", s0_run, MAXBURST);
                end
            end else begin
                s0_run = 0;
                n_cmp++;
                if (o_sr_key_0 !== 5'd0) begin
                    n_bad++;
                    $display("FAIL sr_key_idle: sr_key_0=%0d with search_0 low, required 0", o_sr_key_0);
                end
            end
            if (!o_update_1) begin
                n_cmp++;
                if ({o_up_key_1, o_up_din_1, o_up_del_1} !== 7'd0) begin
                    n_bad++;
                    $display("FAIL up_idle: key=%0d din=%b del=%b with update_1 low, required 0",
                             o_up_key_1, o_up_din_1, o_up_del_1);
                end
            end
            if (s0_log_en) s0_log.push_back(o_search_0);
        end
        @(posedge clk);
        #1;
    endtask

    // Present one command until accepted; record its predicted response
    task automatic push_cmd(input logic [1:0] op, input logic [4:0] key,
                            input logic dat, input logic [3:0] tag);
        bit   acc = 1'b0;
        exp_t e;
        i_cmd_vld = 1'b1; i_cmd_op = op; i_cmd_key = key; i_cmd_dat = dat; i_cmd_tag = tag;
        for (int n = 0; n < 100 && !acc; n++) begin
            acc = (o_cmd_rdy === 1'b1);
            tick();
        end
        i_cmd_vld = 1'b0;
        n_cmp++;
        if (!acc) begin
            n_bad++;
            $display("FAIL push_accept: tag=%0d cmd_rdy stayed %b, required 1", tag, o_cmd_rdy);
        end else begin
            e.tag = tag;
            e.err = (op == 2'd3);
            e.hit = (op == 2'd0) && ref_v[key];
            e.dat = e.hit ? ref_d[key] : 1'b0;
            if (op == 2'd1) begin ref_v[key] = 1'b1; ref_d[key] = dat; end
            if (op == 2'd2) ref_v[key] = 1'b0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int n = 0; n < 60 && sb.size() != 0; n++) tick();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_cmp++;
        if ({o_cmd_rdy, o_search_0, o_update_1, o_rsp_vld} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_outputs: rdy/srch/upd/rsp=%b, required 0000",
                     {o_cmd_rdy, o_search_0, o_update_1, o_rsp_vld});
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (o_cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_rdy: cmd_rdy=%b, required 1", o_cmd_rdy);
        end
    endtask

    task automatic test_single_search();
        push_cmd(2'd0, 5'd5, 1'b0, 4'd3);
        n_cmp++;
        if (o_search_0 !== 1'b0) begin
            n_bad++;
            $display("FAIL search_early: search_0=%b in accept cycle, required 0", o_search_0);
        end
        tick();
        n_cmp++;
        if ({o_search_0, o_sr_key_0} !== {1'b1, 5'd5}) begin
            n_bad++;
            $display("FAIL search_issue: search_0=%b key=%0d, required 1 key=5", o_search_0, o_sr_key_0);
        end
        wait_drain();
    endtask

    task automatic test_update_bp();
        i_up_bp_1 = 1'b1;
        push_cmd(2'd1, 5'd7, 1'b1, 4'd1);
        push_cmd(2'd0, 5'd2, 1'b0, 4'd2);
        for (int n = 0; n < 3; n++) begin
            n_cmp++;
            if ({o_update_1, o_search_0} !== 2'b00) begin
                n_bad++;
                $display("FAIL bp_stall: update_1=%b search_0=%b under backpressure, required 00",
                         o_update_1, o_search_0);
            end
            tick();
        end
        i_up_bp_1 = 1'b0;
        tick();
        n_cmp++;
        if ({o_update_1, o_up_key_1, o_up_din_1, o_up_del_1, o_search_0} !== {1'b1, 5'd7, 1'b1, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL update_issue: upd=%b key=%0d din=%b del=%b srch=%b, required upd=1 key=7 din=1 del=0 srch=0",
                     o_update_1, o_up_key_1, o_up_din_1, o_up_del_1, o_search_0);
        end
        tick();
        n_cmp++;
        if ({o_search_0, o_sr_key_0} !== {1'b1, 5'd2}) begin
            n_bad++;
            $display("FAIL search_after_update: search_0=%b key=%0d, required 1 key=2", o_search_0, o_sr_key_0);
        end
        push_cmd(2'd0, 5'd7, 1'b0, 4'd4);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        logic [4:0] keys [8];
        logic [9:0] pat;
        int first;
        keys = '{5'd5, 5'd7, 5'd2, 5'd5, 5'd7, 5'd1, 5'd5, 5'd3};
        s0_log.delete();
        s0_log_en = 1'b1;
        for (int i = 0; i < 8; i++) push_cmd(2'd0, keys[i], 1'b0, 4'(i + 8));
        wait_drain();
        s0_log_en = 1'b0;
        first = -1;
        for (int i = 0; i < s0_log.size() && first < 0; i++) if (s0_log[i]) first = i;
        pat = '0;
        for (int i = 0; i < 10; i++)
            if (first >= 0 && first + i < s0_log.size()) pat[9-i] = s0_log[first + i];
        n_cmp++;
        if (pat !== 10'b1111011110) begin
            n_bad++;
            $display("FAIL burst_pattern: search_0 pattern=%b, required 1111011110", pat);
        end
    endtask

    task automatic test_fill_wrap();
        i_tbl_ready = 1'b0;
        push_cmd(2'd1, 5'd9, 1'b1, 4'd1);
        push_cmd(2'd0, 5'd9, 1'b0, 4'd2);
        push_cmd(2'd2, 5'd7, 1'b0, 4'd3);
        push_cmd(2'd0, 5'd7, 1'b0, 4'd4);
        for (int n = 0; n < 2; n++) begin
            n_cmp++;
            if ({o_cmd_rdy, o_search_0, o_update_1} !== 3'b000) begin
                n_bad++;
                $display("FAIL full_hold: rdy/srch/upd=%b with 4 queued and table not ready, required 000",
                         {o_cmd_rdy, o_search_0, o_update_1});
            end
            tick();
        end
        i_tbl_ready = 1'b1;
        push_cmd(2'd0, 5'd5, 1'b0, 4'd5);
        push_cmd(2'd2, 5'd9, 1'b0, 4'd6);
        push_cmd(2'd0, 5'd9, 1'b0, 4'd7);
        push_cmd(2'd0, 5'd2, 1'b0, 4'd8);
        wait_drain();
    endtask

    task automatic test_reserved_op();
        push_cmd(2'd3, 5'd11, 1'b1, 4'd9);
        for (int n = 0; n < int'(SRCH_LAT) + 2; n++) begin
            n_cmp++;
            if ({o_search_0, o_update_1} !== 2'b00) begin
                n_bad++;
                $display("FAIL op3_no_strobe: search_0=%b update_1=%b, required 00", o_search_0, o_update_1);
            end
            tick();
        end
        wait_drain();
    endtask

    task automatic test_reset_inflight();
        i_tbl_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_cmd(2'd0, 5'(i + 1), 1'b0, 4'(i + 10));
        i_tbl_ready = 1'b1;
        tick();
        i_cmd_vld = 1'b1; i_cmd_op = 2'd0; i_cmd_key = 5'd5; i_cmd_tag = 4'd15;
        n_cmp++;
        if (o_cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL rdy_after_pop: cmd_rdy=%b, required 1", o_cmd_rdy);
        end
        tick();
        i_cmd_vld = 1'b0;
        i_tbl_ready = 1'b0;
        rst = 1'b1;
        sb.delete();
        tick();
        n_cmp++;
        if ({o_search_0, o_update_1, o_rsp_vld, o_cmd_rdy} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_inflight: srch/upd/rsp/rdy=%b, required 0000",
                     {o_search_0, o_update_1, o_rsp_vld, o_cmd_rdy});
        end
        tick();
        rst = 1'b0;
        i_tbl_ready = 1'b1;
        tick();
        n_cmp++;
        if (o_cmd_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_inflight_rdy: cmd_rdy=%b, required 1", o_cmd_rdy);
        end
        for (int n = 0; n < 8; n++) begin
            n_cmp++;
            if (o_search_0 !== 1'b0) begin
                n_bad++;
                $display("FAIL dropped_cmd_issued: search_0=%b key=%0d after reset, required 0",
                         o_search_0, o_sr_key_0);
            end
            tick();
        end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            ref_v[k] = 1'b0; ref_d[k] = 1'b0; tbl_v[k] = 1'b0; tbl_d[k] = 1'b0;
        end
        ref_v[5] = 1'b1; ref_d[5] = 1'b1;
        tbl_v[5] = 1'b1; tbl_d[5] = 1'b1;
        for (int k = 0; k <= int'(SRCH_LAT); k++) begin
            hist_v[k] = 1'b0; hist_h[k] = 1'b0; hist_d[k] = 1'b0;
        end
        test_reset();
        test_single_search();
        test_update_bp();
        test_back_to_back();
        test_fill_wrap();
        test_reserved_op();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
